serial_sub_ctrl: RTL and testbench
==================================

SERIAL_SUB_CTRL -- requirements
Module: serial_sub_ctrl

Interface
REQ-001 Parameter: WIDTH, 8, operand width in bits (legal range 2..32).
REQ-002 Port: clk  input  1  single clock; all state updates on rising edge.
REQ-003 Port: rst_n  input  1  reset, synchronous, active-low.
REQ-004 Port: start  input  1  request a subtraction; sampled only in IDLE.
REQ-005 Port: a  input  WIDTH  minuend; captured on the accepted start edge.
REQ-006 Port: b  input  WIDTH  subtrahend; captured on the accepted start edge.
REQ-007 Port: busy  output  1  high whenever state is not IDLE.
REQ-008 Port: done  output  1  one-cycle completion pulse.
REQ-009 Port: diff  output  WIDTH  result a-b modulo 2^WIDTH; held until the next accepted start.
REQ-010 Port: borrow_out  output  1  final borrow, high when a < b (unsigned); held with diff.

Function
REQ-011 FSM states SHALL be IDLE, SHIFT and DONE; encoding is free.
REQ-012 IDLE: start=1 at edge E0 SHALL latch a and b into shift registers, clear the borrow register and the bit counter, and go to SHIFT.
REQ-013 SHIFT: each edge SHALL process one bit, LSB first, through the 1-bit cell: d = a_i ^ b_i ^ bin, bout = (~a_i & b_i) | (~(a_i ^ b_i) & bin).
REQ-014 SHIFT: d SHALL be shifted into diff from the MSB side; bout SHALL be registered as bin for the next bit; the counter SHALL increment.
REQ-015 Edges E1..EWIDTH SHALL process bits 0..WIDTH-1; at edge EWIDTH the state SHALL become DONE, with diff and borrow_out final.
REQ-016 DONE: done=1 for exactly the cycle following EWIDTH; edge EWIDTH+1 SHALL return to IDLE with done=0.
REQ-017 Latency from the accepted start edge to done high SHALL be exactly WIDTH cycles; the minimum start-to-start period SHALL be WIDTH+2 cycles.
REQ-018 start while in SHIFT or DONE SHALL be ignored, with no effect on operands, counter or outputs.
REQ-019 a and b SHALL be don't-care outside the accepted start edge; changing them mid-operation SHALL NOT affect the result.
REQ-020 The counter SHALL be $clog2(WIDTH)+1 bits wide; terminal count is WIDTH-1, with no wrap beyond it.
REQ-021 diff and borrow_out SHALL change only during SHIFT; during SHIFT they are intermediate and not valid.
REQ-022 Equal operands SHALL yield diff=0 and borrow_out=0.

Reset
REQ-023 rst_n=0 at any edge, including mid-SHIFT or in DONE, SHALL force state IDLE, busy=0, done=0, diff=0, borrow_out=0, counter=0, borrow register=0 and operand registers=0.
REQ-024 start SHALL be ignored at any edge where rst_n=0; the first start can be accepted at the first edge with rst_n=1.

Structure
REQ-025 A shared package sub_pkg SHALL hold the FSM state typedef (IDLE/SHIFT/DONE) and the default-width constant SUB_WIDTH_DEFAULT=8.
REQ-026 The 1-bit borrow logic SHALL be a sub-module full_sub_cell (inputs a, b, bin; outputs d, bout), instantiated once, and built from two half-subtractor stages plus an OR.
REQ-027 The controller SHALL contain no combinational path from start, a or b to any output.

Verification (WIDTH=8)
REQ-028 a=0x05, b=0x03, start pulsed at E0 -> done high in the cycle after E8, diff=0x02, borrow_out=0, busy high E0..E9.
REQ-029 a=0x03, b=0x05 -> diff=0xFE, borrow_out=1; a=0x00, b=0x01 -> diff=0xFF, borrow_out=1.
REQ-030 a=0xFF, b=0xFF -> diff=0x00, borrow_out=0; a=0xA5, b=0x00 -> diff=0xA5, borrow_out=0.
REQ-031 Start 0x10-0x01, then pulse start at E4 with a=0x00, b=0xFF -> the second start is ignored, result 0x0F with borrow 0, and exactly one done pulse.
REQ-032 Start 0x80-0x01, assert rst_n=0 at E4 -> next cycle all outputs 0 and state IDLE; a new start 0x09-0x04 after release -> diff=0x05 after 8 cycles.
REQ-033 Random compare against (a-b) mod 256 and (a<b) over 1000 operations, with start held high continuously -> each operation is accepted every 10 cycles and all results match.

Source files
------------

// File: rtl/sub_pkg.sv
// ---------------------------------------------------------------------------
// sub_pkg -- shared definitions for the bit-serial subtractor.
//   state_t            : controller FSM states (IDLE / SHIFT / DONE)
//   SUB_WIDTH_DEFAULT  : default operand width in bits
// ---------------------------------------------------------------------------
package sub_pkg;

  localparam int SUB_WIDTH_DEFAULT = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

endpackage : sub_pkg

// File: rtl/full_sub_cell.sv
// ---------------------------------------------------------------------------
// full_sub_cell -- 1-bit full subtractor built from two half-subtractors.
//   a    : minuend bit
//   b    : subtrahend bit
//   bin  : borrow in from the previous (less significant) bit
//   d    : difference bit  a ^ b ^ bin
//   bout : borrow out      (~a & b) | (~(a ^ b) & bin)
// ---------------------------------------------------------------------------
module full_sub_cell (
  input  logic a,
  input  logic b,
  input  logic bin,
  output logic d,
  output logic bout
);

  logic hs1_d;
  logic hs1_b;
  logic hs2_b;

  // First half-subtractor: a - b.
  assign hs1_d = a ^ b;
  assign hs1_b = ~a & b;

  // Second half-subtractor: (a - b) - bin.
  assign d     = hs1_d ^ bin;
  assign hs2_b = ~hs1_d & bin;

  // A borrow can come from only one of the two stages, so OR merges them.
  assign bout  = hs1_b | hs2_b;

endmodule : full_sub_cell

// File: rtl/serial_sub_ctrl.sv
// ---------------------------------------------------------------------------
// serial_sub_ctrl -- bit-serial unsigned subtractor, one bit per clock, LSB
// first. A request is accepted from IDLE, takes WIDTH SHIFT cycles, then a
// single DONE cycle; the result is held until the next accepted request.
//   clk        : clock, rising edge
//   rst_n      : synchronous active-low reset
//   start      : request a subtraction (sampled only in IDLE)
//   a, b       : minuend / subtrahend, captured on the accepted start edge
//   busy       : high whenever the FSM is not in IDLE
//   done       : one-cycle completion pulse
//   diff       : (a - b) mod 2^WIDTH
//   borrow_out : final borrow, high when a < b (unsigned)
// All outputs are driven straight from registers.
// ---------------------------------------------------------------------------
module serial_sub_ctrl
  import sub_pkg::*;
#(
  parameter int WIDTH = SUB_WIDTH_DEFAULT
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             borrow_out
);

  localparam int             CW       = $clog2(WIDTH) + 1;
  localparam logic [CW-1:0]  LAST_BIT = CW'(WIDTH - 1);

  state_t           state;
  state_t           state_nxt;
  logic [WIDTH-1:0] a_sr;
  logic [WIDTH-1:0] b_sr;
  logic [WIDTH-1:0] diff_r;
  logic             bin_r;
  logic             borrow_r;
  logic [CW-1:0]    cnt;
  logic             cell_d;
  logic             cell_bout;

  full_sub_cell u_cell (
    .a    (a_sr[0]),
    .b    (b_sr[0]),
    .bin  (bin_r),
    .d    (cell_d),
    .bout (cell_bout)
  );

  // NOTE: reset is checked inside the clocked block, so it only acts on a
  // rising edge; every register, operands included, is cleared there.
  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // NOTE: the default assignment up front keeps this block free of latches
  // for any state or input combination not named below.
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (start) state_nxt = SHIFT;
      SHIFT:   if (cnt == LAST_BIT) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // sees the pre-edge values of the others (the shift chain relies on it).
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      a_sr     <= '0;
      b_sr     <= '0;
      diff_r   <= '0;
      bin_r    <= 1'b0;
      borrow_r <= 1'b0;
      cnt      <= '0;
    end else begin
      case (state)
        IDLE: begin
          // diff/borrow_out are left alone here: they keep the previous
          // result until the first SHIFT edge of the new operation.
          if (start) begin
            a_sr  <= a;
            b_sr  <= b;
            bin_r <= 1'b0;
            cnt   <= '0;
          end
        end
        SHIFT: begin
          a_sr     <= a_sr >> 1;
          b_sr     <= b_sr >> 1;
          // Difference bits enter at the MSB; after WIDTH shifts bit 0 of
          // the result has reached diff_r[0].
          diff_r   <= {cell_d, diff_r[WIDTH-1:1]};
          bin_r    <= cell_bout;
          borrow_r <= cell_bout;
          // SHIFT is left at LAST_BIT, so cnt tops out at WIDTH, which the
          // extra counter bit holds without wrapping.
          cnt      <= cnt + CW'(1);
        end
        default: ;
      endcase
    end
  end

  assign busy       = (state != IDLE);
  assign done       = (state == DONE);
  assign diff       = diff_r;
  assign borrow_out = borrow_r;

endmodule : serial_sub_ctrl

// File: tb/tb_serial_sub_ctrl.sv
// ---------------------------------------------------------------------------
// tb_serial_sub_ctrl -- directed + random bench for serial_sub_ctrl, WIDTH=8.
// Expected results are pushed to a scoreboard queue when a request is driven
// and popped when the DUT raises done.
// ---------------------------------------------------------------------------
module tb_serial_sub_ctrl;

  localparam int W = 8;

  typedef struct packed {
    logic [W-1:0] d;
    logic         bo;
  } exp_t;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         start;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         busy;
  logic         done;
  logic [W-1:0] diff;
  logic         borrow_out;

  int   total = 0;
  int   bad   = 0;
  int   done_cnt = 0;
  exp_t sb[$];

  serial_sub_ctrl #(.WIDTH(W)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .a          (a),
    .b          (b),
    .busy       (busy),
    .done       (done),
    .diff       (diff),
    .borrow_out (borrow_out)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (done === 1'b1) done_cnt++;

  // Advance past the next rising edge; inputs change and outputs are read
  // 1 time unit after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic exp_t model(input logic [W-1:0] av, input logic [W-1:0] bv);
    exp_t e;
    e.d  = av - bv;
    e.bo = (av < bv);
    return e;
  endfunction

  // Wait (bounded) for done; returns the number of ticks taken.
  task automatic wait_done(output int n);
    n = 0;
    while (done !== 1'b1 && n < 40) begin
      tick();
      n++;
    end
  endtask

  task automatic pop_compare(input string tag);
    exp_t e;
    check({tag, "_sb_nonempty"}, 32'(sb.size() != 0), 32'd1);
    if (sb.size() != 0) begin
      e = sb.pop_front();
      check({tag, "_diff"},   32'(diff),       32'(e.d));
      check({tag, "_borrow"}, 32'(borrow_out), 32'(e.bo));
    end
  endtask

  // One full operation from IDLE: start pulse, scrambled operands mid-run,
  // latency check, result check, then return to IDLE with result held.
  task automatic run_op(input string tag, input logic [W-1:0] av, input logic [W-1:0] bv);
    int n;
    exp_t e;
    e = model(av, bv);
    a = av; b = bv; start = 1'b1;
    sb.push_back(e);
    tick();                                   // E0
    check({tag, "_busy_e0"}, 32'(busy), 32'd1);
    check({tag, "_done_e0"}, 32'(done), 32'd0);
    start = 1'b0;
    a = W'($urandom); b = W'($urandom);
    wait_done(n);
    check({tag, "_latency"}, 32'(n), 32'(W));
    check({tag, "_busy_done"}, 32'(busy), 32'd1);
    pop_compare(tag);
    tick();                                   // E(W+1)
    check({tag, "_done_low"}, 32'(done), 32'd0);
    check({tag, "_idle"}, 32'(busy), 32'd0);
    tick();
    check({tag, "_held_diff"},   32'(diff),       32'(e.d));
    check({tag, "_held_borrow"}, 32'(borrow_out), 32'(e.bo));
  endtask

  initial begin
    int   n;
    int   dc0;
    exp_t e;

    // Reset with start held high: start must be ignored.
    rst_n = 1'b0; start = 1'b1; a = 8'h12; b = 8'h34;
    tick(); tick();
    check("rst_busy",   32'(busy),       32'd0);
    check("rst_done",   32'(done),       32'd0);
    check("rst_diff",   32'(diff),       32'd0);
    check("rst_borrow", 32'(borrow_out), 32'd0);
    start = 1'b0;
    rst_n = 1'b1;
    tick();

    // Basic and boundary operations.
    run_op("p05m03", 8'h05, 8'h03);
    run_op("p03m05", 8'h03, 8'h05);
    run_op("p00m01", 8'h00, 8'h01);
    run_op("pffmff", 8'hFF, 8'hFF);
    run_op("pa5m00", 8'hA5, 8'h00);
    run_op("p00mff", 8'h00, 8'hFF);

    // Start during SHIFT is ignored.
    dc0 = done_cnt;
    a = 8'h10; b = 8'h01; start = 1'b1;
    sb.push_back(model(8'h10, 8'h01));
    tick();                                   // E0
    start = 1'b0;
    tick(); tick(); tick();                   // E1..E3
    a = 8'h00; b = 8'hFF; start = 1'b1;
    tick();                                   // E4
    start = 1'b0;
    wait_done(n);
    check("ign_latency", 32'(n), 32'(W - 4));
    pop_compare("ign");
    for (int i = 0; i < 12; i++) tick();
    check("ign_one_done", 32'(done_cnt - dc0), 32'd1);
    check("ign_idle",     32'(busy),           32'd0);

    // Reset mid-SHIFT aborts the operation.
    a = 8'h80; b = 8'h01; start = 1'b1;
    tick();                                   // E0
    start = 1'b0;
    tick(); tick(); tick();                   // E1..E3
    rst_n = 1'b0;
    tick();                                   // E4
    check("abort_busy",   32'(busy),       32'd0);
    check("abort_done",   32'(done),       32'd0);
    check("abort_diff",   32'(diff),       32'd0);
    check("abort_borrow", 32'(borrow_out), 32'd0);
    rst_n = 1'b1;
    tick();
    check("abort_still_idle", 32'(busy), 32'd0);
    run_op("p09m04", 8'h09, 8'h04);

    // Back-to-back random operations with start held high.
    a = W'($urandom); b = W'($urandom); start = 1'b1;
    sb.push_back(model(a, b));
    for (int i = 0; i < 1000; i++) begin
      if (i > 0) begin
        tick();
        n = 1;
      end else begin
        n = 0;
      end
      while (done !== 1'b1 && n < 40) begin
        tick();
        n++;
      end
      check("rnd_period", 32'(n), (i == 0) ? 32'(W + 1) : 32'(W + 2));
      pop_compare("rnd");
      if (i < 999) begin
        // Captured two edges from now, after DONE -> IDLE.
        a = W'($urandom); b = W'($urandom);
        e = model(a, b);
        sb.push_back(e);
      end else begin
        start = 1'b0;
      end
    end
    tick(); tick(); tick();
    check("rnd_final_idle", 32'(busy),     32'd0);
    check("rnd_sb_drained", 32'(sb.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule : tb_serial_sub_ctrl
